dm_result_streamer: RTL and testbench
=====================================

Name: dm_result_streamer

Overview:
- Hardware end-of-test unloader for the CPU + IM/DM system.
- Snoops the data-memory write port for the end-of-simulation marker: word 0xFFFFFFFF written to word address 0x3FFF.
- On the marker, or on a cycle-count timeout, reads NUM_WORDS consecutive DM words starting at word 0x2000 through a dedicated read port.
- Streams each word out over a valid/ready interface, so results can be extracted without hierarchical memory peeking.

Parameters:
- ADDR_W, 14: DM word-address width.
- NUM_WORDS, 64: words to unload; legal range 1..(2^ADDR_W - TEST_START).
- TEST_START, 14'h2000: first word address unloaded.
- SIM_END_ADDR, 14'h3FFF: marker word address.
- END_CODE, 32'hFFFFFFFF: marker value.
- MAX_CYCLES, 100000: timeout in clk cycles after reset release.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- dm_we, input, 1: snooped DM write strobe; full-word write.
- dm_waddr, input, ADDR_W: snooped DM write word address.
- dm_wdata, input, 32: snooped DM write data.
- rd_en, output, 1: DM read request.
- rd_addr, output, ADDR_W: DM read word address.
- rd_data, input, 32: DM read data, valid the cycle after rd_en.
- out_valid, output, 1: stream word valid.
- out_ready, input, 1: stream sink ready.
- out_data, output, 32: unloaded word.
- out_index, output, ADDR_W: word address of out_data.
- out_last, output, 1: high with the final word.
- busy, output, 1: unload in progress.
- done, output, 1: sticky; unload complete.
- timeout, output, 1: sticky; unload was started by timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, cycle counter 0, word counter 0. Reset is asynchronous: out_valid and rd_en drop immediately, including mid-unload.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE
  - Cycle counter increments every cycle.
  - A trigger (dm_we && dm_waddr==SIM_END_ADDR && dm_wdata==END_CODE) sampled at edge k moves to READ.
  - If instead the counter reaches MAX_CYCLES-1, set timeout=1 and move to READ.
  - Trigger and timeout in the same cycle: trigger wins, timeout stays 0.
  - Marker with partial mismatch (wrong data, or dm_we=0) is ignored.
- READ, one cycle: rd_en=1, rd_addr=TEST_START+word_cnt, busy=1.
- WAIT, one cycle: rd_en=0; rd_data is registered into out_data at the end of the cycle, and out_index is set to the same address.
- SEND
  - out_valid=1; out_data, out_index and out_last stay stable until the handshake.
  - Handshake: out_valid && out_ready at a rising edge.
  - After a handshake, if word_cnt==NUM_WORDS-1, go to DONE; otherwise increment word_cnt and go to READ.
  - out_valid is never withdrawn before the handshake.
- Latency:
  - Trigger at edge k gives rd_en high during cycle k+1 and out_valid high from cycle k+3.
  - With out_ready held at 1, one word is transferred every 3 cycles.
  - Full unload takes 3*NUM_WORDS cycles after the trigger; done rises at edge k+3*NUM_WORDS.
- out_last = (word_cnt==NUM_WORDS-1) while in SEND.
- DONE: done=1, busy=0, out_valid=0. Terminal until rst; further markers are ignored.
- Markers arriving during READ/WAIT/SEND are ignored; no restart.
- Arithmetic: word_cnt is ADDR_W+1 bits. rd_addr = TEST_START+word_cnt truncated to ADDR_W bits; the legal parameter range guarantees no wrap.
- Cycle counter is 32-bit and saturates once it leaves IDLE (frozen).

Decomposition:
- Package dm_dump_pkg:
  - state enum (IDLE, READ, WAIT, SEND, DONE);
  - constants DM_ADDR_W=14, SIM_END_ADDR, END_CODE, TEST_START, default MAX_CYCLES.
- One sub-module, dm_timeout_counter:
  - 32-bit counter with enable and a MAX_CYCLES compare;
  - single-cycle expire pulse; freezes when disabled.

Test Plan:
- Marker: NUM_WORDS=4, DM[0x2000..0x2003]=11111111, 22222222, 33333333, 44444444, out_ready=1, write 0xFFFFFFFF to 0x3FFF at edge 20.
  - Expect four words in order with out_index 0x2000..0x2003 and out_last only on the 4th.
  - Expect done=1 at edge 32, timeout=0.
- Back-pressure: same setup, out_ready low for 5 cycles after the first out_valid.
  - out_data=11111111 is held stable, no rd_en is issued, and the transfer completes when ready rises.
- Near-miss markers: write 0xFFFFFFFE to 0x3FFF, then 0xFFFFFFFF to 0x3FFE.
  - busy stays 0.
  - A correct marker afterwards starts the unload.
- Timeout: MAX_CYCLES=50, no marker.
  - timeout=1 and rd_en high in the cycle after edge 49; the full unload completes.
  - A marker issued during the unload has no effect.
- Tie: marker written in the exact cycle the counter reaches MAX_CYCLES-1.
  - The unload starts with timeout=0.
- Reset mid-stream: assert rst during the 2nd SEND.
  - out_valid, busy and rd_en drop asynchronously.
  - After release, a new marker restarts at out_index 0x2000.

Source files
------------

// File: rtl/dm_dump_pkg.sv
// Shared constants and FSM state type for the end-of-test DM unloader.
package dm_dump_pkg;

  localparam int               DM_ADDR_W       = 14;
  localparam logic [13:0]      DM_TEST_START   = 14'h2000;
  localparam logic [13:0]      DM_SIM_END_ADDR = 14'h3FFF;
  localparam logic [31:0]      DM_END_CODE     = 32'hFFFF_FFFF;
  localparam int unsigned      DM_MAX_CYCLES   = 100000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/dm_timeout_counter.sv
// Free-running cycle counter that fires a one-cycle expire pulse and freezes when disabled.
module dm_timeout_counter
  import dm_dump_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = DM_MAX_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic expire_o
);

  // Pulse one cycle early so the consumer acts on the edge where the count becomes MAX_CYCLES-1.
  localparam logic [31:0] EXPIRE_AT = MAX_CYCLES - 32'd2;

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/dm_result_streamer.sv
// Snoops the DM write port for the end-of-test marker (or times out), then reads
// NUM_WORDS result words from DM and streams them out over valid/ready.
module dm_result_streamer
  import dm_dump_pkg::*;
#(
  parameter int                 ADDR_W       = DM_ADDR_W,
  parameter int                 NUM_WORDS    = 64,
  parameter logic [ADDR_W-1:0]  TEST_START   = DM_TEST_START,
  parameter logic [ADDR_W-1:0]  SIM_END_ADDR = DM_SIM_END_ADDR,
  parameter logic [31:0]        END_CODE     = DM_END_CODE,
  parameter int unsigned        MAX_CYCLES   = DM_MAX_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_waddr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [ADDR_W-1:0] out_index_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int             CW       = ADDR_W + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_WORDS - 1);

  state_e            state_q;
  logic [CW-1:0]     word_cnt_q;
  logic [CW-1:0]     word_inc;
  logic              rd_en_q, out_valid_q, out_last_q, busy_q, done_q, timeout_q;
  logic [ADDR_W-1:0] rd_addr_q, out_index_q;
  logic [31:0]       out_data_q;
  logic              trigger, expire;

  assign trigger  = dm_we_i && (dm_waddr_i == SIM_END_ADDR) && (dm_wdata_i == END_CODE);
  assign word_inc = word_cnt_q + CW'(1);

  dm_timeout_counter #(.MAX_CYCLES(MAX_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == IDLE),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A marker in the same cycle as expiry counts as a normal end, not a timeout.
          if (trigger || expire) begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'({1'b0, TEST_START} + word_cnt_q);
            busy_q    <= 1'b1;
            timeout_q <= !trigger;
          end
        end
        READ: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          out_data_q  <= rd_data_i;
          out_index_q <= rd_addr_q;
          out_last_q  <= (word_cnt_q == LAST_IDX);
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (word_cnt_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              word_cnt_q <= word_inc;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= ADDR_W'({1'b0, TEST_START} + word_inc);
              state_q    <= READ;
            end
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_dm_result_streamer.sv
// Self-checking bench for dm_result_streamer: DM read model, stream scoreboard, directed corner cases.
module tb_dm_result_streamer;

  localparam int AW   = 14;
  localparam int NW   = 4;
  localparam int MAXC = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_waddr = '0;
  logic [31:0]   dm_wdata = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [AW-1:0] out_index;
  logic          out_last, busy, done, timeout;

  dm_result_streamer #(.NUM_WORDS(NW), .MAX_CYCLES(MAXC)) dut (
    .clk_i(clk), .rst_i(rst), .dm_we_i(dm_we), .dm_waddr_i(dm_waddr), .dm_wdata_i(dm_wdata),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_index_o(out_index), .out_last_o(out_last), .busy_o(busy), .done_o(done),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  logic [31:0] dm [0:16383];
  always @(posedge clk) if (rd_en) rd_data <= dm[rd_addr];

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          exp_start;
  } vec_t;
  vec_t vecs [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor: the word on the bus must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("stream_unexpected_word", out_valid, 1'b0);
      else begin
        e = exp_q[0];
        chk("stream_data",  out_data,  e.data);
        chk("stream_index", out_index, e.idx);
        chk("stream_last",  out_last,  e.last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic goto_edge(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic push_words();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.data = dm[14'h2000 + i];
      e.idx  = AW'(14'h2000 + i);
      e.last = (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0; out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_at(input int e, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    goto_edge(e - 1);
    dm_we = we; dm_waddr = a; dm_wdata = d;
    goto_edge(e);
    dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) dm[i] = 32'h0;
    for (int i = 0; i < NW; i++) dm[14'h2000 + i] = 32'h1111_1111 * (i + 1);

    // Marker at edge 20, ready held high.
    do_reset();
    push_words();
    write_at(20, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    chk("mk_rd_en_k1", rd_en, 1'b1);
    chk("mk_rd_addr_k1", rd_addr, 14'h2000);
    chk("mk_busy_k1", busy, 1'b1);
    goto_edge(21); chk("mk_rd_en_k2", rd_en, 1'b0);
    goto_edge(22); chk("mk_valid_k3", out_valid, 1'b1);
    goto_edge(31); chk("mk_done_early", done, 1'b0);
    goto_edge(32);
    chk("mk_done", done, 1'b1);
    chk("mk_timeout", timeout, 1'b0);
    chk("mk_busy_end", busy, 1'b0);
    chk("mk_drained", exp_q.size(), 0);

    // Back-pressure on the first word for five cycles.
    do_reset();
    push_words();
    out_ready = 1'b0;
    write_at(20, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    for (int e = 23; e <= 27; e++) begin
      goto_edge(e);
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_data_held", out_data, 32'h1111_1111);
      chk("bp_no_rd_en", rd_en, 1'b0);
    end
    out_ready = 1'b1;
    goto_edge(28);
    chk("bp_valid_drop", out_valid, 1'b0);
    chk("bp_next_rd_addr", rd_addr, 14'h2001);
    goto_edge(36); chk("bp_done_early", done, 1'b0);
    goto_edge(37); chk("bp_done", done, 1'b1);
    chk("bp_drained", exp_q.size(), 0);

    // Near-miss markers, then a correct one.
    vecs[0] = '{1'b1, 14'h3FFF, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{1'b1, 14'h3FFE, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 14'h3FFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{1'b1, 14'h3FFF, 32'hFFFF_FFFF, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].exp_start) push_words();
      write_at(10 + 4 * i, vecs[i].we, vecs[i].addr, vecs[i].data);
      chk("nm_busy", busy, vecs[i].exp_start);
      chk("nm_rd_en", rd_en, vecs[i].exp_start);
    end
    goto_edge(33); chk("nm_done_early", done, 1'b0);
    goto_edge(34); chk("nm_done", done, 1'b1);
    chk("nm_drained", exp_q.size(), 0);

    // Timeout with no marker; later markers are ignored.
    do_reset();
    push_words();
    goto_edge(48);
    chk("to_rd_en_pre", rd_en, 1'b0);
    chk("to_timeout_pre", timeout, 1'b0);
    goto_edge(49);
    chk("to_rd_en", rd_en, 1'b1);
    chk("to_timeout", timeout, 1'b1);
    chk("to_rd_addr", rd_addr, 14'h2000);
    write_at(55, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    goto_edge(60); chk("to_done_early", done, 1'b0);
    goto_edge(61);
    chk("to_done", done, 1'b1);
    chk("to_timeout_sticky", timeout, 1'b1);
    write_at(65, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    goto_edge(70);
    chk("to_done_terminal", busy, 1'b0);
    chk("to_drained", exp_q.size(), 0);

    // Marker in the same cycle as expiry: trigger wins.
    do_reset();
    push_words();
    write_at(49, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    chk("tie_rd_en", rd_en, 1'b1);
    chk("tie_timeout", timeout, 1'b0);
    goto_edge(61);
    chk("tie_done", done, 1'b1);
    chk("tie_timeout_end", timeout, 1'b0);
    chk("tie_drained", exp_q.size(), 0);

    // Asynchronous reset during the second SEND, then during a READ.
    do_reset();
    push_words();
    write_at(20, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    goto_edge(25);
    chk("rs_valid_2nd", out_valid, 1'b1);
    chk("rs_index_2nd", out_index, 14'h2001);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid_async", out_valid, 1'b0);
    chk("rs_busy_async", busy, 1'b0);
    chk("rs_rd_en_async", rd_en, 1'b0);
    do_reset();
    push_words();
    write_at(20, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    goto_edge(23);
    chk("rs_rd_en_read", rd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rs_rd_en_drop", rd_en, 1'b0);
    do_reset();
    push_words();
    write_at(20, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
    goto_edge(22);
    chk("rs_restart_index", out_index, 14'h2000);
    goto_edge(32);
    chk("rs_restart_done", done, 1'b1);
    chk("rs_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
